// File: rtl/traffic_signal_timed_pkg.sv
// Shared types and constants for the highway/country-road signal controller.
package traffic_signal_timed_pkg;

    typedef logic [2:0] state_t;
    typedef logic [1:0] lamp_t;

    // State codes; 6 and 7 are illegal and recover to S_HWY_GREEN.
    localparam state_t S_HWY_GREEN    = 3'd0;
    localparam state_t S_HWY_YELLOW   = 3'd1;
    localparam state_t S_ALLRED_TO_C  = 3'd2;
    localparam state_t S_CNTRY_GREEN  = 3'd3;
    localparam state_t S_CNTRY_YELLOW = 3'd4;
    localparam state_t S_ALLRED_TO_H  = 3'd5;

    localparam lamp_t LAMP_RED    = 2'b00;
    localparam lamp_t LAMP_YELLOW = 2'b01;
    localparam lamp_t LAMP_GREEN  = 2'b10;

    // Largest of the four phase lengths; sizes the phase timer.
    function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/traffic_signal_timed_phase_timer.sv
// Saturating per-phase cycle counter: clear has priority over increment.
module traffic_signal_timed_phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear, else step unless already all-ones (no wrap into a false min-met).
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register; reset is folded into clr_i by the caller.
    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_signal_timed.sv
// Moore traffic controller: highway green by default, country green on demand,
// yellow and all-red clearance between them, emergency preempt back to highway.
module traffic_signal_timed
    import traffic_signal_timed_pkg::*;
#(
    parameter int unsigned HWY_MIN_GREEN   = 4,
    parameter int unsigned YELLOW_TICKS    = 3,
    parameter int unsigned ALLRED_TICKS    = 1,
    parameter int unsigned CNTRY_MAX_GREEN = 8,
    parameter int unsigned CNT_W =
        $clog2(max_of4(HWY_MIN_GREEN, YELLOW_TICKS, ALLRED_TICKS, CNTRY_MAX_GREEN)) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             emerg,
    output logic [1:0]       hwy_signal,
    output logic [1:0]       cntry_road_signal,
    output logic [2:0]       state_out,
    output logic [2:0]       next_state_out,
    output logic [CNT_W-1:0] timer_out
);

    // Last timer value of each phase: the transition happens on the edge where timer hits it.
    localparam logic [CNT_W-1:0] HWY_LAST    = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] CNTRY_LAST  = CNT_W'(CNTRY_MAX_GREEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q;
    logic             timer_clr;

    // Next-state selection in priority order; reset overrides every input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HWY_GREEN: begin
                if (!emerg && x && (timer_q >= HWY_LAST)) state_d = S_HWY_YELLOW;
            end
            S_HWY_YELLOW: begin
                if (emerg)                           state_d = S_HWY_GREEN;
                else if (timer_q == YELLOW_LAST)     state_d = S_ALLRED_TO_C;
            end
            S_ALLRED_TO_C: begin
                if (emerg)                           state_d = S_HWY_GREEN;
                else if (timer_q == ALLRED_LAST)     state_d = S_CNTRY_GREEN;
            end
            S_CNTRY_GREEN: begin
                if (emerg || !x || (timer_q == CNTRY_LAST)) state_d = S_CNTRY_YELLOW;
            end
            S_CNTRY_YELLOW: begin
                // Preempt never shortens the country yellow.
                if (timer_q == YELLOW_LAST)          state_d = S_ALLRED_TO_H;
            end
            S_ALLRED_TO_H: begin
                if (timer_q == ALLRED_LAST)          state_d = S_HWY_GREEN;
            end
            default: state_d = S_HWY_GREEN;
        endcase
        if (reset) state_d = S_HWY_GREEN;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_HWY_GREEN;
        else       state_q <= state_d;
    end

    assign timer_clr = reset || (state_d != state_q);

    traffic_signal_timed_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk_i   (clk),
        .clr_i   (timer_clr),
        .inc_i   (1'b1),
        .count_o (timer_q)
    );

    // Lamp decode from the registered state only; illegal codes show all-red.
    always_comb begin
        hwy_signal        = LAMP_RED;
        cntry_road_signal = LAMP_RED;
        case (state_q)
            S_HWY_GREEN:    hwy_signal        = LAMP_GREEN;
            S_HWY_YELLOW:   hwy_signal        = LAMP_YELLOW;
            S_CNTRY_GREEN:  cntry_road_signal = LAMP_GREEN;
            S_CNTRY_YELLOW: cntry_road_signal = LAMP_YELLOW;
            default: ;
        endcase
    end

    assign state_out      = state_q;
    assign next_state_out = state_d;
    assign timer_out      = timer_q;

endmodule
